bpm_int_capture: RTL

//  Downstream of the BPM mux/integrator. Captures the four 17-bit integrated I/Q sums once per

---
 rtl/bpm_int_capture.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/bpm_int_capture.sv
// bpm_int_capture: latches the four integrated I/Q sums once per bunch window, when
// bunch_strb falls. Each record carries the count of strobe-high cycles in the window.
// Records go into a small first-word fall-through FIFO, which is read out over valid/ready.
// Optional build macro: BPM_CAP_TIMESTAMP_EN. It adds ts_out, a per-record sample of a
// free-running 32-bit cycle counter taken at the capture edge.
module bpm_int_capture #(
    parameter int DEPTH   = 4,
    parameter int CAP_DLY = 1,
    parameter int W       = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bunch_strb,
    input  logic         dac_cond,
    input  logic [W-1:0] bpm1_i_in,
    input  logic [W-1:0] bpm1_q_in,
    input  logic [W-1:0] bpm2_i_in,
    input  logic [W-1:0] bpm2_q_in,
    input  logic         rd_ready,
    output logic         rd_valid,
    output logic [W-1:0] bpm1_i_out,
    output logic [W-1:0] bpm1_q_out,
    output logic [W-1:0] bpm2_i_out,
    output logic [W-1:0] bpm2_q_out,
    output logic [7:0]   nbunch_out,
    output logic [4:0]   fill,
    output logic         ovf,
    output logic [7:0]   ovf_cnt
`ifdef BPM_CAP_TIMESTAMP_EN
    ,
    output logic [31:0]  ts_out
`endif
);

    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FILL_W = 5;
    localparam int BASE_W = 4 * W + 8;
`ifdef BPM_CAP_TIMESTAMP_EN
    localparam int REC_W  = BASE_W + 32;
`else
    localparam int REC_W  = BASE_W;
`endif

    logic               bs_d;
    logic [CAP_DLY-1:0] cap_line;
    logic [7:0]         nb_cnt;
    logic               nb_restart;

    logic               fall;
    logic               cap_fire;
    logic               push;
    logic               abort_evt;
    logic               pop;
    logic               full;
    logic               wr_en;
    logic               drop;

    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      rd_ptr_nxt;
    logic [FILL_W-1:0]  fill_after_pop;
    logic [FILL_W-1:0]  fill_nxt;

    logic [REC_W-1:0]   rec_in;
    logic [REC_W-1:0]   head_q;
    logic [REC_W-1:0]   head_nxt;
    logic [REC_W-1:0]   mem [DEPTH];

`ifdef BPM_CAP_TIMESTAMP_EN
    logic [31:0]        cyc_cnt;

    // Free-running cycle counter; it wraps, and records sample it at the capture edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
        end
    end

    assign rec_in = {cyc_cnt, nb_cnt, bpm2_q_in, bpm2_i_in, bpm1_q_in, bpm1_i_in};
    assign ts_out = head_q[BASE_W +: 32];
`else
    assign rec_in = {nb_cnt, bpm2_q_in, bpm2_i_in, bpm1_q_in, bpm1_i_in};
`endif

    // A window closes on the first low sample after a high one. The delay line lets the
    // integrator's output register settle before the sums are taken. An abort at either end
    // of the line kills that capture only; captures that overlap still flow through the line.
    assign fall      = bs_d & ~bunch_strb;
    assign cap_fire  = cap_line[CAP_DLY-1];
    assign push      = cap_fire & ~dac_cond;
    assign abort_evt = dac_cond & (fall | cap_fire);

    assign rd_valid  = (fill != '0);
    assign pop       = rd_valid & rd_ready;
    assign full      = (fill == FILL_W'(DEPTH));
    assign wr_en     = push & (~full | pop);
    assign drop      = push & full & ~pop;

    // Edge-detect register and capture delay line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bs_d     <= 1'b0;
            cap_line <= '0;
        end else begin
            bs_d     <= bunch_strb;
            cap_line <= (cap_line << 1) | CAP_DLY'(fall & ~dac_cond);
        end
    end

    // Count the strobe-high cycles of each window. Once a window has been captured or
    // aborted, the next high cycle starts the count over at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nb_cnt     <= 8'd0;
            nb_restart <= 1'b0;
        end else begin
            if (bunch_strb) begin
                if (nb_restart) begin
                    nb_cnt <= 8'd1;
                end else if (nb_cnt != 8'hFF) begin
                    nb_cnt <= nb_cnt + 8'd1;
                end
            end
            if (cap_fire || abort_evt) begin
                nb_restart <= 1'b1;
            end else if (bunch_strb) begin
                nb_restart <= 1'b0;
            end
        end
    end

    // Record storage; the contents need no reset because fill gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= rec_in;
        end
    end

    // Work out the head record for the next cycle. If the pop leaves the FIFO empty and a
    // push lands on the same edge, the new record becomes the head at once. No read of the
    // slot being written is needed for that case.
    always_comb begin
        rd_ptr_nxt     = rd_ptr;
        if (pop) begin
            rd_ptr_nxt = rd_ptr + 1'b1;
        end
        fill_after_pop = fill - {{(FILL_W-1){1'b0}}, pop};
        fill_nxt       = fill_after_pop + {{(FILL_W-1){1'b0}}, wr_en};
        if (fill_after_pop == '0) begin
            head_nxt   = rec_in;
        end else begin
            head_nxt   = mem[rd_ptr_nxt];
        end
    end

    // Pointer, occupancy, overflow and head-register update. The head register holds its
    // value when the FIFO drains, so the outputs keep the last popped record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fill    <= '0;
            head_q  <= '0;
            ovf     <= 1'b0;
            ovf_cnt <= 8'd0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_nxt;
            fill   <= fill_nxt;
            if (fill_nxt != '0) begin
                head_q <= head_nxt;
            end
            if (drop) begin
                ovf <= 1'b1;
                if (ovf_cnt != 8'hFF) begin
                    ovf_cnt <= ovf_cnt + 8'd1;
                end
            end
        end
    end

    assign bpm1_i_out = head_q[0 +: W];
    assign bpm1_q_out = head_q[W +: W];
    assign bpm2_i_out = head_q[2*W +: W];
    assign bpm2_q_out = head_q[3*W +: W];
    assign nbunch_out = head_q[4*W +: 8];

endmodule
